// File: rtl/eth_rxfilt_ctrl.sv
// eth_rxfilt_ctrl
// Configuration controller for the RX address filter. The host writes the
// station MAC, two hash tables and the mode bits (Pro/Bro/Iam) into shadow
// registers over a simple req/ack port. The shadow copy is transferred to the
// active copy that drives the address checker only at a frame boundary
// (StateIdle or StateDrop), so filtering never changes in the middle of a frame.
//
// Optional feature: define ETH_RXFILT_MISSCNT_EN to build a saturating
// counter of Address_mismatch pulses, readable and clearable at address 5.
//
// Ports
//   MRxClk, Resetn      clock (rising edge) and asynchronous active-low reset
//   CfgReq/CfgWe        host request (held until CfgAck) and write enable
//   CfgAddr/CfgWData    register address and write data
//   CfgRData/CfgAck     read data and its one-cycle acknowledge
//   StateIdle/StateDrop RX state machine status; either one marks a boundary
//   Address_mismatch    one-cycle pulse per rejected frame
//   MAC, HASH0, HASH1   active filter configuration
//   r_Pro/r_Bro/r_Iam   active mode bits
//   CfgPending          shadow written but not yet committed
//   CommitTimeout       one-cycle pulse when a commit has waited COMMIT_MAX cycles
module eth_rxfilt_ctrl #(
  parameter int CNT_W      = 16,
  parameter int COMMIT_MAX = 255
) (
  input  logic        MRxClk,
  input  logic        Resetn,
  input  logic        CfgReq,
  input  logic        CfgWe,
  input  logic [2:0]  CfgAddr,
  input  logic [31:0] CfgWData,
  output logic [31:0] CfgRData,
  output logic        CfgAck,
  input  logic        StateIdle,
  input  logic        StateDrop,
  input  logic        Address_mismatch,
  output logic [47:0] MAC,
  output logic [31:0] HASH0,
  output logic [31:0] HASH1,
  output logic        r_Pro,
  output logic        r_Bro,
  output logic        r_Iam,
  output logic        CfgPending,
  output logic        CommitTimeout
);

  localparam int TW = $clog2(COMMIT_MAX + 1);
  localparam logic [TW-1:0] WaitMax = TW'(COMMIT_MAX);

  typedef enum logic [1:0] {Idle, AckCycle, CommitCycle} ctrlState_t;

  ctrlState_t state, nextState;

  logic          reqArmed;
  logic          accept;
  logic          doCommit;
  logic          boundary;
  logic          shadowWrite;
  logic [31:0]   readMux;
  logic [47:0]   shadowMac;
  logic [31:0]   shadowHash0;
  logic [31:0]   shadowHash1;
  logic [2:0]    shadowMode;
  logic [2:0]    activeMode;
  logic [TW-1:0] waitTimer;
  logic [CNT_W-1:0] missCnt;

  assign boundary = StateIdle | StateDrop;
  assign CfgAck   = (state == AckCycle);
  assign r_Pro    = activeMode[0];
  assign r_Bro    = activeMode[1];
  assign r_Iam    = activeMode[2];

  // State register for the IDLE/ACK/COMMIT controller.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) state <= Idle;
    else         state <= nextState;
  end

  // Next-state logic. A host request takes priority over a commit, so a
  // write that lands together with a boundary pushes the commit back by one
  // pass through IDLE. Both ACK and COMMIT last a single cycle.
  always_comb begin
    nextState   = state;
    accept      = 1'b0;
    doCommit    = 1'b0;
    shadowWrite = 1'b0;
    case (state)
      Idle: begin
        if (CfgReq && reqArmed) begin
          accept    = 1'b1;
          nextState = AckCycle;
        end else if (CfgPending && boundary) begin
          doCommit  = 1'b1;
          nextState = CommitCycle;
        end
      end
      AckCycle:    nextState = Idle;
      CommitCycle: nextState = Idle;
      default:     nextState = Idle;
    endcase
    if (accept && CfgWe && (CfgAddr <= 3'd4)) shadowWrite = 1'b1;
  end

  // A held request is serviced once: after acceptance the host has to be
  // seen with CfgReq low before another request is taken.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn)      reqArmed <= 1'b0;
    else if (accept)  reqArmed <= 1'b0;
    else if (!CfgReq) reqArmed <= 1'b1;
  end

  // Read path always shows the shadow registers, not the active copy, so the
  // host sees what it wrote even before the commit happens.
  always_comb begin
    readMux = '0;
    case (CfgAddr)
      3'd0:    readMux = shadowMac[31:0];
      3'd1:    readMux = {16'h0000, shadowMac[47:32]};
      3'd2:    readMux = shadowHash0;
      3'd3:    readMux = shadowHash1;
      3'd4:    readMux = {29'd0, shadowMode};
      3'd5:    readMux = 32'(missCnt);
      default: readMux = '0;
    endcase
  end

  // Read data is captured at the edge that raises CfgAck and is zero at all
  // other times.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn)              CfgRData <= '0;
    else if (accept && !CfgWe) CfgRData <= readMux;
    else                       CfgRData <= '0;
  end

  // Shadow registers and the pending flag. Every shadow write marks the
  // configuration pending even when the value does not change; only a commit
  // clears it, and a commit never coincides with a write.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      shadowMac   <= '0;
      shadowHash0 <= '0;
      shadowHash1 <= '0;
      shadowMode  <= '0;
      CfgPending  <= 1'b0;
    end else if (shadowWrite) begin
      CfgPending <= 1'b1;
      case (CfgAddr)
        3'd0:    shadowMac[31:0]  <= CfgWData;
        3'd1:    shadowMac[47:32] <= CfgWData[15:0];
        3'd2:    shadowHash0      <= CfgWData;
        3'd3:    shadowHash1      <= CfgWData;
        default: shadowMode       <= CfgWData[2:0];
      endcase
    end else if (doCommit) begin
      CfgPending <= 1'b0;
    end
  end

  // Active copy feeding the address checker. It is loaded on the edge that
  // enters COMMIT, which is an edge where a boundary was sampled.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      MAC        <= '0;
      HASH0      <= '0;
      HASH1      <= '0;
      activeMode <= '0;
    end else if (doCommit) begin
      MAC        <= shadowMac;
      HASH0      <= shadowHash0;
      HASH1      <= shadowHash1;
      activeMode <= shadowMode;
    end
  end

  // Wait timer: measures how long a pending commit has been starved of a
  // boundary. It pulses CommitTimeout on reaching the limit and then holds
  // there; it only reports, it never forces a commit.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      waitTimer     <= '0;
      CommitTimeout <= 1'b0;
    end else if (doCommit) begin
      waitTimer     <= '0;
      CommitTimeout <= 1'b0;
    end else if (CfgPending && !boundary && (waitTimer != WaitMax)) begin
      waitTimer     <= waitTimer + 1'b1;
      CommitTimeout <= ((waitTimer + 1'b1) == WaitMax);
    end else begin
      CommitTimeout <= 1'b0;
    end
  end

`ifdef ETH_RXFILT_MISSCNT_EN
  // Saturating miss counter. A host write to address 5 clears it; a mismatch
  // arriving on the same edge as the clear is still counted.
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      missCnt <= '0;
    end else if (accept && CfgWe && (CfgAddr == 3'd5)) begin
      missCnt <= Address_mismatch ? CNT_W'(1) : '0;
    end else if (Address_mismatch && !(&missCnt)) begin
      missCnt <= missCnt + 1'b1;
    end
  end
`else
  // Without the statistics option the counter is a constant zero and the
  // mismatch input is not used.
  logic unusedMismatch;
  assign unusedMismatch = Address_mismatch;
  assign missCnt = '0;
`endif

endmodule

// File: tb/tb_eth_rxfilt_ctrl.sv
// tb_eth_rxfilt_ctrl
// Directed bench for eth_rxfilt_ctrl. Host transactions push their expected
// read data into a scoreboard queue; a monitor pops and compares it whenever
// CfgAck is seen. Filter outputs are checked directly from the stimulus.
// Built with COMMIT_MAX=4 and CNT_W=2 so timeout and saturation are short.
module tb_eth_rxfilt_ctrl;

  logic        MRxClk;
  logic        Resetn;
  logic        CfgReq;
  logic        CfgWe;
  logic [2:0]  CfgAddr;
  logic [31:0] CfgWData;
  logic [31:0] CfgRData;
  logic        CfgAck;
  logic        StateIdle;
  logic        StateDrop;
  logic        Address_mismatch;
  logic [47:0] MAC;
  logic [31:0] HASH0;
  logic [31:0] HASH1;
  logic        r_Pro;
  logic        r_Bro;
  logic        r_Iam;
  logic        CfgPending;
  logic        CommitTimeout;

`ifdef ETH_RXFILT_MISSCNT_EN
  localparam logic [31:0] ExpMissSat = 32'd3;
  localparam logic [31:0] ExpMissOne = 32'd1;
`else
  localparam logic [31:0] ExpMissSat = 32'd0;
  localparam logic [31:0] ExpMissOne = 32'd0;
`endif

  typedef struct {
    bit          isRead;
    logic [31:0] data;
    string       name;
  } expect_t;

  expect_t sb[$];
  int checks = 0;
  int errors = 0;
  int timeoutCount = 0;
  logic prevAck = 1'b0;

  eth_rxfilt_ctrl #(.CNT_W(2), .COMMIT_MAX(4)) dut (
    .MRxClk(MRxClk), .Resetn(Resetn), .CfgReq(CfgReq), .CfgWe(CfgWe),
    .CfgAddr(CfgAddr), .CfgWData(CfgWData), .CfgRData(CfgRData), .CfgAck(CfgAck),
    .StateIdle(StateIdle), .StateDrop(StateDrop), .Address_mismatch(Address_mismatch),
    .MAC(MAC), .HASH0(HASH0), .HASH1(HASH1), .r_Pro(r_Pro), .r_Bro(r_Bro),
    .r_Iam(r_Iam), .CfgPending(CfgPending), .CommitTimeout(CommitTimeout)
  );

  // Free-running clock.
  initial MRxClk = 1'b0;
  always #5 MRxClk = ~MRxClk;

  // Compare one value against its expectation and keep the counters.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One host transaction, started on a falling edge. The expectation is
  // queued first; the task returns on the falling edge where CfgAck is seen.
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data,
                               input logic [31:0] expRd, input string name, input bit pulseMiss);
    expect_t e;
    bit got;
    e.isRead = !we;
    e.data   = expRd;
    e.name   = name;
    sb.push_back(e);
    CfgReq   = 1'b1;
    CfgWe    = we;
    CfgAddr  = addr;
    CfgWData = data;
    if (pulseMiss) Address_mismatch = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge MRxClk);
      Address_mismatch = 1'b0;
      if (CfgAck) got = 1'b1;
    end
    if (!got) checkOutput({name, "_ackTimeout"}, 64'd0, 64'd1);
    CfgReq = 1'b0;
    CfgWe  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge MRxClk);
  endtask

  // Monitor: every acknowledge must be a single cycle and must match the
  // oldest queued expectation.
  initial begin
    expect_t e;
    forever begin
      @(negedge MRxClk);
      if (CfgAck) begin
        checkOutput("ackWidth", {63'd0, prevAck}, 64'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpectedAck", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.isRead) checkOutput(e.name, {32'd0, CfgRData}, {32'd0, e.data});
        end
      end
      prevAck = CfgAck;
    end
  end

  // Count the cycles in which CommitTimeout is high.
  initial begin
    forever begin
      @(negedge MRxClk);
      if (CommitTimeout) timeoutCount++;
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Resetn = 1'b0; CfgReq = 1'b0; CfgWe = 1'b0; CfgAddr = '0; CfgWData = '0;
    StateIdle = 1'b0; StateDrop = 1'b0; Address_mismatch = 1'b0;
    tick(3);
    checkOutput("rstMAC", {16'd0, MAC}, 64'd0);
    checkOutput("rstHASH0", {32'd0, HASH0}, 64'd0);
    checkOutput("rstHASH1", {32'd0, HASH1}, 64'd0);
    checkOutput("rstMode", {61'd0, r_Iam, r_Bro, r_Pro}, 64'd0);
    checkOutput("rstCtl", {60'd0, CfgAck, CfgPending, CommitTimeout, 1'b0}, 64'd0);
    checkOutput("rstRData", {32'd0, CfgRData}, 64'd0);
    Resetn = 1'b1;
    tick(2);

    for (int a = 0; a < 6; a++) begin
      applyStimulus(1'b0, 3'(a), 32'd0, 32'd0, $sformatf("rstRead%0d", a), 1'b0);
      tick(1);
    end
    checkOutput("rstPending", {63'd0, CfgPending}, 64'd0);

    // Writes without a boundary stay in the shadow copy.
    applyStimulus(1'b1, 3'd0, 32'h33445566, 32'd0, "wrMacLo", 1'b0);
    tick(1);
    applyStimulus(1'b1, 3'd1, 32'hABCD1122, 32'd0, "wrMacHi", 1'b0);
    tick(1);
    checkOutput("macHeld", {16'd0, MAC}, 64'd0);
    checkOutput("pendingSet", {63'd0, CfgPending}, 64'd1);
    tick(6);
    checkOutput("timeoutOnce1", 64'(timeoutCount), 64'd1);
    checkOutput("macStill0", {16'd0, MAC}, 64'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'h33445566, "rdShadowLo", 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd1, 32'd0, 32'h00001122, "rdShadowHi", 1'b0);
    tick(1);
    StateIdle = 1'b1;
    tick(1);
    checkOutput("macCommitted", {16'd0, MAC}, 64'h0000_1122_3344_5566);
    checkOutput("pendingClr", {63'd0, CfgPending}, 64'd0);

    // Write landing together with the boundary defers the commit.
    StateIdle = 1'b0;
    tick(1);
    StateIdle = 1'b1;
    applyStimulus(1'b1, 3'd4, 32'h0000_0002, 32'd0, "wrMode", 1'b0);
    checkOutput("broDeferA", {62'd0, r_Bro, CfgPending}, 64'b01);
    tick(1);
    checkOutput("broDeferB", {62'd0, r_Bro, CfgPending}, 64'b01);
    tick(1);
    checkOutput("broCommitted", {60'd0, r_Iam, r_Bro, r_Pro, CfgPending}, 64'b0100);
    checkOutput("timeoutStill1", 64'(timeoutCount), 64'd1);

    // Long wait without a boundary: one timeout pulse, no forced commit.
    StateIdle = 1'b0;
    tick(1);
    applyStimulus(1'b1, 3'd2, 32'hDEADBEEF, 32'd0, "wrHash0", 1'b0);
    tick(10);
    checkOutput("hash0Held", {32'd0, HASH0}, 64'd0);
    checkOutput("hash0Pending", {63'd0, CfgPending}, 64'd1);
    checkOutput("timeoutOnce2", 64'(timeoutCount), 64'd2);
    applyStimulus(1'b0, 3'd2, 32'd0, 32'hDEADBEEF, "rdHash0", 1'b0);
    tick(1);
    StateDrop = 1'b1;
    tick(1);
    checkOutput("hash0Committed", {32'd0, HASH0}, 64'h0000_0000_DEAD_BEEF);
    checkOutput("dropPendingClr", {63'd0, CfgPending}, 64'd0);
    checkOutput("macKept", {16'd0, MAC}, 64'h0000_1122_3344_5566);
    StateDrop = 1'b0;
    tick(1);

    // Miss counter saturation, clear, and clear-with-pulse.
    for (int p = 0; p < 5; p++) begin
      Address_mismatch = 1'b1;
      tick(1);
      Address_mismatch = 1'b0;
      tick(1);
    end
    applyStimulus(1'b0, 3'd5, 32'd0, ExpMissSat, "missSat", 1'b0);
    tick(1);
    applyStimulus(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0, "missClrPulse", 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd5, 32'd0, ExpMissOne, "missClrPlusOne", 1'b0);
    tick(1);
    applyStimulus(1'b1, 3'd5, 32'd0, 32'd0, "missClr", 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd5, 32'd0, 32'd0, "missZero", 1'b0);
    tick(1);

    // Remaining registers and the unused addresses.
    applyStimulus(1'b0, 3'd4, 32'd0, 32'd2, "rdMode", 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd3, 32'd0, 32'd0, "rdHash1", 1'b0);
    tick(1);
    applyStimulus(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0, "wrAddr6", 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd6, 32'd0, 32'd0, "rdAddr6", 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd7, 32'd0, 32'd0, "rdAddr7", 1'b0);
    tick(1);

    // Reset in the middle of a handshake.
    begin
      expect_t e;
      e.isRead = 1'b0;
      e.data   = 32'd0;
      e.name   = "wrLost";
      sb.push_back(e);
    end
    CfgReq = 1'b1; CfgWe = 1'b1; CfgAddr = 3'd2; CfgWData = 32'h12345678;
    tick(1);
    checkOutput("ackBeforeReset", {63'd0, CfgAck}, 64'd1);
    #1 Resetn = 1'b0;
    #1;
    checkOutput("ackAsyncDrop", {63'd0, CfgAck}, 64'd0);
    checkOutput("rstMidMAC", {16'd0, MAC}, 64'd0);
    checkOutput("rstMidHASH0", {32'd0, HASH0}, 64'd0);
    checkOutput("rstMidMode", {61'd0, r_Iam, r_Bro, r_Pro}, 64'd0);
    checkOutput("rstMidPending", {63'd0, CfgPending}, 64'd0);
    tick(1);
    CfgReq = 1'b0; CfgWe = 1'b0;
    tick(1);
    Resetn = 1'b1;
    tick(2);
    applyStimulus(1'b0, 3'd2, 32'd0, 32'd0, "rdAfterReset", 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, "rdMacAfterReset", 1'b0);
    tick(2);

    checkOutput("sbDrained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
